// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and the load/store queue
// (LSQ). It allows one outstanding memory transaction at a time and keeps at least one idle cycle
// between transactions.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin arbitration; the pointer flips after every grant.
//              undefined -> fixed priority; the LSQ wins a tie.
//
// Parameters:
//   STORE_BIT  lsq_op bit that marks a store (1 = store, 0 = load)
//   TIMEOUT    longest time, in cycles, that a transaction waits for mem_ack
//
// Ports:
//   clk, rst (async, active-low), rollback (pipeline flush)
//   if_req/if_addr -> if_ready/if_rdata                       fetch channel
//   lsq_op/lsq_addr/lsq_wdata -> lsq_rd_ready/lsq_rd_data,
//     lsq_wr_ready                                            load/store channel
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata      memory bus
//   err                                                       sticky timeout flag
module mem_arbiter #(
  parameter int unsigned STORE_BIT = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rollback,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic [5:0]  lsq_op,
  input  logic [31:0] lsq_addr,
  input  logic [31:0] lsq_wdata,
  output logic        lsq_rd_ready,
  output logic [31:0] lsq_rd_data,
  output logic        lsq_wr_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIfBusy, StLsqBusy} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_store_q, pend_store_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic [31:0]      pend_wdata_q, pend_wdata_d;
  logic             cur_store_q, cur_store_d;
  // The current transaction was hit by a rollback, so its ready pulse is dropped.
  logic             squash_q, squash_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             if_ready_q, if_ready_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic             rd_ready_q, rd_ready_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             wr_ready_q, wr_ready_d;
  logic             err_q, err_d;
`ifdef ARB_RR_EN
  // 1: the LSQ owns the round-robin pointer; 0: IF owns it.
  logic             rr_lsq_q, rr_lsq_d;
`endif

  logic        new_op, new_store, slot_accept, pend_kill, slot_live;
  logic        lsq_req, sel_store, grant_lsq, grant_if, suppress;
  logic [31:0] sel_addr, sel_wdata;

  assign new_op    = |lsq_op;
  assign new_store = lsq_op[STORE_BIT];
  // A load that arrives in the same cycle as a rollback is stale and is dropped.
  assign slot_accept = new_op && !pend_valid_q && (state_q != StLsqBusy) &&
                       !(rollback && !new_store);
  assign pend_kill = pend_valid_q && rollback && !pend_store_q;
  assign slot_live = pend_valid_q && !pend_kill;

  // A newly accepted op can be granted in the cycle it arrives, which keeps the LSQ latency at 1.
  assign lsq_req   = slot_live || slot_accept;
  assign sel_store = slot_live ? pend_store_q : new_store;
  assign sel_addr  = slot_live ? pend_addr_q  : lsq_addr;
  assign sel_wdata = slot_live ? pend_wdata_q : lsq_wdata;

  always_comb begin
    grant_lsq = 1'b0;
    grant_if  = 1'b0;
    if (state_q == StIdle) begin
      if (lsq_req && if_req) begin
`ifdef ARB_RR_EN
        grant_lsq = rr_lsq_q;
        grant_if  = !rr_lsq_q;
`else
        grant_lsq = 1'b1;
`endif
      end else begin
        grant_lsq = lsq_req;
        grant_if  = if_req;
      end
    end
  end

  assign suppress = squash_q || rollback;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_store_d = pend_store_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    cur_store_d  = cur_store_q;
    squash_d     = squash_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ready_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    rd_ready_d   = 1'b0;
    rd_data_d    = rd_data_q;
    wr_ready_d   = 1'b0;
    err_d        = err_q;
`ifdef ARB_RR_EN
    rr_lsq_d     = rr_lsq_q;
`endif

    if (pend_kill) pend_valid_d = 1'b0;
    if (slot_accept) begin
      pend_valid_d = 1'b1;
      pend_store_d = new_store;
      pend_addr_d  = lsq_addr;
      pend_wdata_d = lsq_wdata;
    end

    unique case (state_q)
      StIdle: begin
        if (grant_lsq) begin
          state_d      = StLsqBusy;
          pend_valid_d = 1'b0;
          cur_store_d  = sel_store;
          squash_d     = 1'b0;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = sel_store;
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
`ifdef ARB_RR_EN
          rr_lsq_d     = 1'b0;
`endif
        end else if (grant_if) begin
          state_d     = StIfBusy;
          cur_store_d = 1'b0;
          // A fetch granted during a flush is already stale.
          squash_d    = rollback;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
`ifdef ARB_RR_EN
          rr_lsq_d    = 1'b1;
`endif
        end
      end
      StIfBusy, StLsqBusy: begin
        // A committed store is never squashed.
        if (rollback && !(state_q == StLsqBusy && cur_store_q)) squash_d = 1'b1;
        if (mem_ack) begin
          state_d   = StIdle;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          if (state_q == StIfBusy) begin
            if_ready_d = !suppress;
            if_rdata_d = mem_rdata;
          end else if (cur_store_q) begin
            wr_ready_d = 1'b1;
          end else begin
            rd_ready_d = !suppress;
            rd_data_d  = mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_store_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      cur_store_q  <= 1'b0;
      squash_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      rd_ready_q   <= 1'b0;
      rd_data_q    <= '0;
      wr_ready_q   <= 1'b0;
      err_q        <= 1'b0;
`ifdef ARB_RR_EN
      rr_lsq_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_store_q <= pend_store_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      cur_store_q  <= cur_store_d;
      squash_q     <= squash_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ready_q   <= if_ready_d;
      if_rdata_q   <= if_rdata_d;
      rd_ready_q   <= rd_ready_d;
      rd_data_q    <= rd_data_d;
      wr_ready_q   <= wr_ready_d;
      err_q        <= err_d;
`ifdef ARB_RR_EN
      rr_lsq_q     <= rr_lsq_d;
`endif
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign if_ready     = if_ready_q;
  assign if_rdata     = if_rdata_q;
  assign lsq_rd_ready = rd_ready_q;
  assign lsq_rd_data  = rd_data_q;
  assign lsq_wr_ready = wr_ready_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT = 4). Inputs change on the falling edge
// and outputs are sampled there too.
module tb_mem_arbiter;
  localparam int unsigned To = 4;
  localparam logic [5:0] OpLoad  = 6'b000001;
  localparam logic [5:0] OpStore = 6'b001000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rollback = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic [5:0]  lsq_op = '0;
  logic [31:0] lsq_addr = '0;
  logic [31:0] lsq_wdata = '0;
  logic        lsq_rd_ready;
  logic [31:0] lsq_rd_data;
  logic        lsq_wr_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STORE_BIT(3), .TIMEOUT(To)) dut (
    .clk(clk), .rst(rst), .rollback(rollback),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .lsq_op(lsq_op), .lsq_addr(lsq_addr), .lsq_wdata(lsq_wdata),
    .lsq_rd_ready(lsq_rd_ready), .lsq_rd_data(lsq_rd_data), .lsq_wr_ready(lsq_wr_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  // Ack for one cycle; returns on the falling edge where the ready pulse is visible.
  task automatic pulse_ack(input logic [31:0] d);
    mem_ack = 1'b1;
    mem_rdata = d;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h10;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, lsq_rd_ready, lsq_rd_data,
         lsq_wr_ready, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h err=%b, want all zero",
               mem_req, mem_we, mem_addr, err);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      failures++;
      $display("FAIL first_grant: got req=%b addr=%h, want 1 00000010", mem_req, mem_addr);
    end
    pulse_ack(32'hA5A5_0001);
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL first_fetch_ready: got %b %h, want 1 a5a50001", if_ready, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    logic we_seen;
    if_req = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_grant: got req=%b addr=%h we=%b, want 1 00000100 0",
               mem_req, mem_addr, mem_we);
    end
    we_seen = mem_we;
    repeat (2) begin
      @(negedge clk);
      we_seen |= mem_we;
    end
    pulse_ack(32'hDEAD_BEEF);
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ready: got rdy=%b data=%h req=%b, want 1 deadbeef 0",
               if_ready, if_rdata, mem_req);
    end
    checks++;
    if (we_seen !== 1'b0) begin
      failures++;
      $display("FAIL fetch_we: got we asserted=%b, want 0", we_seen);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin
      failures++;
      $display("FAIL fetch_pulse_width: got if_ready=%b, want 0", if_ready);
    end
  endtask

  task automatic test_store;
    logic req_seen;
    lsq_op = OpStore;
    lsq_addr = 32'h40;
    lsq_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 ||
        mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL store_grant: got req=%b we=%b addr=%h wdata=%h, want 1 1 00000040 12345678",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    // A load offered while the LSQ is busy must be ignored.
    lsq_op = OpLoad;
    lsq_addr = 32'h44;
    @(negedge clk);
    lsq_op = '0;
    pulse_ack(32'h0);
    checks++;
    if (lsq_wr_ready !== 1'b1 || lsq_rd_ready !== 1'b0) begin
      failures++;
      $display("FAIL store_ready: got wr=%b rd=%b, want 1 0", lsq_wr_ready, lsq_rd_ready);
    end
    req_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      req_seen |= mem_req;
    end
    checks++;
    if (req_seen !== 1'b0) begin
      failures++;
      $display("FAIL busy_op_ignored: got mem_req seen=%b, want 0", req_seen);
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] exp2;
`ifdef ARB_RR_EN
    exp2 = 32'h200;
`else
    exp2 = 32'h304;
`endif
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h200;
    lsq_op = OpLoad;
    lsq_addr = 32'h300;
    @(negedge clk);
    lsq_op = '0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
      failures++;
      $display("FAIL arb_first: got req=%b addr=%h, want 1 00000300", mem_req, mem_addr);
    end
    pulse_ack(32'h1111_0000);
    checks++;
    if (lsq_rd_ready !== 1'b1 || lsq_rd_data !== 32'h1111_0000) begin
      failures++;
      $display("FAIL arb_first_ready: got %b %h, want 1 11110000", lsq_rd_ready, lsq_rd_data);
    end
    lsq_op = OpLoad;
    lsq_addr = 32'h304;
    @(negedge clk);
    lsq_op = '0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp2) begin
      failures++;
      $display("FAIL arb_second: got req=%b addr=%h, want 1 %h", mem_req, mem_addr, exp2);
    end
`ifdef ARB_RR_EN
    pulse_ack(32'h2222_0000);
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h2222_0000) begin
      failures++;
      $display("FAIL arb_second_ready: got if %b %h, want 1 22220000", if_ready, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin
      failures++;
      $display("FAIL arb_third: got req=%b addr=%h, want 1 00000304", mem_req, mem_addr);
    end
    pulse_ack(32'h3333_0000);
    checks++;
    if (lsq_rd_ready !== 1'b1 || lsq_rd_data !== 32'h3333_0000) begin
      failures++;
      $display("FAIL arb_third_ready: got rd %b %h, want 1 33330000", lsq_rd_ready, lsq_rd_data);
    end
`else
    pulse_ack(32'h2222_0000);
    checks++;
    if (lsq_rd_ready !== 1'b1 || lsq_rd_data !== 32'h2222_0000) begin
      failures++;
      $display("FAIL arb_second_ready: got rd %b %h, want 1 22220000", lsq_rd_ready, lsq_rd_data);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      failures++;
      $display("FAIL arb_third: got req=%b addr=%h, want 1 00000200", mem_req, mem_addr);
    end
    pulse_ack(32'h3333_0000);
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h3333_0000) begin
      failures++;
      $display("FAIL arb_third_ready: got if %b %h, want 1 33330000", if_ready, if_rdata);
    end
    if_req = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_rollback;
    logic req_seen;
    // In-flight load is flushed: the bus still completes, but no read pulse follows.
    lsq_op = OpLoad;
    lsq_addr = 32'h80;
    @(negedge clk);
    lsq_op = '0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
      failures++;
      $display("FAIL rb_load_grant: got req=%b addr=%h, want 1 00000080", mem_req, mem_addr);
    end
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rb_load_inflight: got mem_req=%b, want 1", mem_req);
    end
    pulse_ack(32'hBAD0_0001);
    checks++;
    if (lsq_rd_ready !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rb_load_suppress: got rd=%b req=%b, want 0 0", lsq_rd_ready, mem_req);
    end
    // Back in idle: a fetch issued now is granted after one cycle.
    if_req = 1'b1;
    if_addr = 32'h88;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h88) begin
      failures++;
      $display("FAIL rb_idle_after: got req=%b addr=%h, want 1 00000088", mem_req, mem_addr);
    end
    if_req = 1'b0;
    rollback = 1'b1;
    pulse_ack(32'hBAD0_0002);
    rollback = 1'b0;
    checks++;
    if (if_ready !== 1'b0) begin
      failures++;
      $display("FAIL rb_fetch_coincide: got if_ready=%b, want 0", if_ready);
    end
    // In-flight store survives a rollback.
    lsq_op = OpStore;
    lsq_addr = 32'h90;
    lsq_wdata = 32'h55;
    @(negedge clk);
    lsq_op = '0;
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    pulse_ack(32'h0);
    checks++;
    if (lsq_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL rb_store_ready: got wr=%b, want 1", lsq_wr_ready);
    end
    // New load coinciding with rollback is dropped.
    lsq_op = OpLoad;
    lsq_addr = 32'h98;
    rollback = 1'b1;
    @(negedge clk);
    lsq_op = '0;
    rollback = 1'b0;
    req_seen = mem_req;
    repeat (2) begin
      @(negedge clk);
      req_seen |= mem_req;
    end
    checks++;
    if (req_seen !== 1'b0) begin
      failures++;
      $display("FAIL rb_new_load_drop: got mem_req seen=%b, want 0", req_seen);
    end
    // New store coinciding with rollback is accepted.
    lsq_op = OpStore;
    lsq_addr = 32'hA0;
    lsq_wdata = 32'h77;
    rollback = 1'b1;
    @(negedge clk);
    lsq_op = '0;
    rollback = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'hA0) begin
      failures++;
      $display("FAIL rb_new_store: got req=%b we=%b addr=%h, want 1 1 000000a0",
               mem_req, mem_we, mem_addr);
    end
    pulse_ack(32'h0);
    checks++;
    if (lsq_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL rb_new_store_ready: got wr=%b, want 1", lsq_wr_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    logic rdy_seen;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_before_timeout: got %b, want 0", err);
    end
    if_req = 1'b1;
    if_addr = 32'h500;
    @(negedge clk);
    if_req = 1'b0;
    n = 0;
    rdy_seen = 1'b0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      rdy_seen |= if_ready | lsq_rd_ready | lsq_wr_ready;
      @(negedge clk);
    end
    rdy_seen |= if_ready | lsq_rd_ready | lsq_wr_ready;
    checks++;
    if (n != To) begin
      failures++;
      $display("FAIL timeout_cycles: got %0d cycles of mem_req, want %0d", n, To);
    end
    checks++;
    if (err !== 1'b1 || rdy_seen !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: got err=%b ready_seen=%b, want 1 0", err, rdy_seen);
    end
    lsq_op = OpStore;
    lsq_addr = 32'h600;
    lsq_wdata = 32'hCAFE;
    @(negedge clk);
    lsq_op = '0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin
      failures++;
      $display("FAIL after_timeout_grant: got req=%b addr=%h, want 1 00000600", mem_req, mem_addr);
    end
    pulse_ack(32'h0);
    checks++;
    if (lsq_wr_ready !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL after_timeout_ready: got wr=%b err=%b, want 1 1", lsq_wr_ready, err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen;
    if_req = 1'b1;
    if_addr = 32'h700;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin
      failures++;
      $display("FAIL midrst_grant: got req=%b addr=%h, want 1 00000700", mem_req, mem_addr);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ready, if_rdata, lsq_rd_ready, lsq_rd_data,
         lsq_wr_ready, err} !== '0) begin
      failures++;
      $display("FAIL midrst_async: got req=%b addr=%h err=%b, want all zero",
               mem_req, mem_addr, err);
    end
    @(negedge clk);
    if_req = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= if_ready | mem_req;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_ready: got ready/req seen=%b, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_arbitration();
    test_rollback();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STORE_BIT, default 3, meaning the lsq_op bit that marks a store (set = store, clear = load).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a memory transaction waits for mem_ack.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-low reset
- rollback  in  1  pipeline flush
- if_req  in  1  fetch request; level, held until if_ready
- if_addr  in  32  fetch address
- if_ready  out  1  fetch data valid; 1-cycle pulse
- if_rdata  out  32  fetch data
- lsq_op  in  6  LSQ operation; nonzero for one cycle = request
- lsq_addr  in  32  LSQ address
- lsq_wdata  in  32  store data
- lsq_rd_ready  out  1  load data valid; pulse
- lsq_rd_data  out  32  load data
- lsq_wr_ready  out  1  store done; pulse
- mem_req  out  1  memory request; level
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory done; 1-cycle pulse
- mem_rdata  in  32  memory read data, valid with mem_ack
- err  out  1  sticky timeout flag

Function
REQ-005 The block SHALL latch a nonzero lsq_op into a one-deep pending slot (op, addr, wdata); a new nonzero lsq_op while the slot is full or LSQ_BUSY SHALL be ignored.
REQ-006 The FSM SHALL have three states: IDLE, IF_BUSY and LSQ_BUSY.
REQ-007 From IDLE, when a request exists, the FSM SHALL select a winner (REQ-015), drive mem_req/mem_addr/mem_we/mem_wdata registered, and enter the matching BUSY state the next cycle.
REQ-008 In a BUSY state, mem_req and the address/data outputs SHALL be held stable until mem_ack.
REQ-009 On mem_ack the block SHALL:
- drop mem_req;
- pulse exactly one of if_ready, lsq_rd_ready or lsq_wr_ready for one cycle, with data registered from mem_rdata;
- return to IDLE.
REQ-010 Request-to-grant latency SHALL be 1 cycle; back-to-back transactions SHALL leave at least 1 IDLE cycle between them.
REQ-011 A cycle counter SHALL run in the BUSY states. When it reaches TIMEOUT without mem_ack, the block SHALL drop mem_req, set err (sticky until reset), return to IDLE and discard the transaction without any ready pulse.
REQ-012 On rollback:
- A pending or in-flight load SHALL be discarded: an in-flight load completes on the bus, but lsq_rd_ready is suppressed.
- A pending or in-flight store SHALL NOT be discarded (stores are committed).
- An in-flight fetch completes, but if_ready is suppressed.
REQ-013 If rollback and mem_ack coincide on a load or fetch, the ready pulse SHALL be suppressed.
REQ-014 If a nonzero lsq_op and rollback coincide, the new load SHALL be dropped and a new store SHALL be accepted.
REQ-015 Arbitration between if_req and the LSQ pending slot SHALL be per REQ-019.

Reset
REQ-016 While rst=0, the block SHALL hold:
- state IDLE, pending slot empty, counter 0, round-robin pointer set to LSQ;
- all outputs 0, including err.
REQ-017 Reset asserted mid-transaction SHALL abort immediately and produce no ready pulse after release.
REQ-018 The first grant SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-019 Macro ARB_RR_EN SHALL select the arbitration policy:
- Defined: round-robin; the pointer flips to the other requester after each grant, and the pointer owner wins on a tie.
- Undefined: fixed priority; the LSQ always wins on a tie.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Fetch: if_req=1, if_addr=0x100; mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> if_ready pulse, if_rdata=0xDEADBEEF, mem_we=0 throughout.
- Store: lsq_op with bit3=1, lsq_addr=0x40, lsq_wdata=0x12345678; ack after 2 cycles -> mem_we=1, mem_wdata=0x12345678, lsq_wr_ready pulse.
- Simultaneous load and fetch, twice in a row, without ARB_RR_EN -> LSQ granted both times; with ARB_RR_EN -> LSQ then IF.
- Rollback during an in-flight load at address 0x80 -> mem_ack accepted, no lsq_rd_ready, FSM in IDLE the next cycle; the same case with a store -> lsq_wr_ready still pulses.
- TIMEOUT=4 with no mem_ack -> mem_req drops after 4 cycles, err=1, no ready pulse, and the next request is served normally.
- Reset asserted while in IF_BUSY -> all outputs 0 asynchronously, and no if_ready after release.
